// File: rtl/csr_pkg.sv
// Shared definitions for the CSR weight-memory consumers: bus field widths,
// the accumulator FSM state encoding and a saturating add helper.
package csr_pkg;

  localparam int CSR_ADDR_W = 14;
  localparam int CSR_IDX_W  = 10;
  localparam int CSR_WT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PTR    = 3'd1,
    ST_PTRW   = 3'd2,
    ST_STREAM = 3'd3,
    ST_EMIT   = 3'd4,
    ST_FIN    = 3'd5
  } csr_state_e;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range.
  // Operands must come from fields narrower than 32 bits so the raw sum cannot wrap.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/csr_spike_accum_if.sv
// Read-only bus between the accumulator and its two synchronous memories:
// the row-pointer ROM and the CSR {index,weight} memory. Read data is valid
// one cycle after the address.
interface csr_spike_accum_if #(
  parameter int ROW_W = 4
) ();

  logic        [ROW_W-1:0]               ptr_addr;
  logic        [csr_pkg::CSR_ADDR_W-1:0] ptr_data;
  logic        [csr_pkg::CSR_ADDR_W-1:0] w_addr;
  logic signed [csr_pkg::CSR_WT_W-1:0]   w_weight;
  logic        [csr_pkg::CSR_IDX_W-1:0]  w_index;

  modport master (
    output ptr_addr,
    output w_addr,
    input  ptr_data,
    input  w_weight,
    input  w_index
  );

  modport slave (
    input  ptr_addr,
    input  w_addr,
    output ptr_data,
    output w_weight,
    output w_index
  );

endinterface

// File: rtl/csr_sat_acc.sv
// Signed saturating accumulator with sticky saturation. sum_o is the value the
// accumulator holds after this cycle's input is applied, so a consumer can
// capture the final sum in the same cycle it clears the accumulator.
module csr_sat_acc
  import csr_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] in_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic signed [31:0]      raw_sum;
  logic signed [31:0]      clamped;

  // Next accumulator value; once a clamp has happened the value is frozen until clear.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_d   = acc_q;
    sat_d   = sat_q;
    raw_sum = 32'(acc_q) + 32'(in_i);
    clamped = sat_add(32'(acc_q), 32'(in_i), ACC_W);
    if (en_i && !sat_q) begin
      acc_d = ACC_W'(clamped);
      sat_d = (clamped != raw_sum);
    end
  end

  assign sum_o = acc_d;

  // Accumulator and sticky saturation flag; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: rtl/csr_spike_accum.sv
// Walks the CSR rows of one layer, fetches each row's {index,weight} words,
// gates them by the latched input spike vector and emits one saturated signed
// sum per row. One full pass of N_ROWS rows per accepted start pulse.
module csr_spike_accum
  import csr_pkg::*;
#(
  parameter  int N_ROWS = 10,
  parameter  int N_IN   = 1024,
  parameter  int ACC_W  = 18,
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_IN-1:0]         spikes,
  csr_spike_accum_if.master       mem,
  output logic                    out_valid,
  output logic [ROW_W-1:0]        out_row,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    busy,
  output logic                    done
);

  // Spike vector zero-padded to the full index space so indices >= N_IN read as 0.
  localparam int                SPK_W    = 1 << CSR_IDX_W;
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(N_ROWS - 1);

  csr_state_e              state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ROW_W-1:0]        ptr_addr_q, ptr_addr_d;
  logic [CSR_ADDR_W-1:0]   base_q, base_d;
  logic [CSR_ADDR_W-1:0]   end_q, end_d;
  logic [CSR_ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    out_valid_q, out_valid_d;
  logic [ROW_W-1:0]        out_row_q, out_row_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [N_IN-1:0]         spk_q, spk_d;

  logic [SPK_W-1:0]        spk_pad;
  logic                    hit;
  logic                    acc_clr;
  logic                    acc_en;
  logic signed [ACC_W-1:0] wt_sext;
  logic signed [ACC_W-1:0] acc_sum;

  assign spk_pad = SPK_W'(spk_q);
  assign hit     = spk_pad[mem.w_index];
  assign acc_en  = vld_q & hit;
  assign wt_sext = ACC_W'($signed(mem.w_weight));

  csr_sat_acc #(.ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .in_i  (wt_sext),
    .sum_o (acc_sum)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the row/address/result datapath it steers.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    ptr_addr_d  = ptr_addr_q;
    base_d      = base_q;
    end_d       = end_q;
    w_addr_d    = w_addr_q;
    vld_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_sum_d   = out_sum_q;
    spk_d       = spk_q;
    acc_clr     = 1'b0;

    // busy stays up through the done cycle, so a start coincident with done is ignored.
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          spk_d      = spikes;
          busy_d     = 1'b1;
          row_d      = '0;
          base_d     = '0;
          ptr_addr_d = '0;
          state_d    = ST_PTR;
        end
      end
      ST_PTR: begin
        state_d = ST_PTRW;
      end
      ST_PTRW: begin
        end_d = mem.ptr_data;
        // An end pointer at or below the base (empty or malformed row) skips streaming.
        if (mem.ptr_data <= base_q) begin
          state_d = ST_EMIT;
        end else begin
          w_addr_d = base_q;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        vld_d = 1'b1;
        if (w_addr_q == end_q - 1'b1) state_d  = ST_EMIT;
        else                          w_addr_d = w_addr_q + 1'b1;
      end
      ST_EMIT: begin
        // The last returned word arrives here; acc_sum already includes it.
        out_valid_d = 1'b1;
        out_row_d   = row_q;
        out_sum_d   = acc_sum;
        acc_clr     = 1'b1;
        base_d      = end_q;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          base_d  = '0;
          state_d = ST_FIN;
        end else begin
          row_d      = row_q + 1'b1;
          ptr_addr_d = row_q + 1'b1;
          state_d    = ST_PTR;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      ptr_addr_q  <= '0;
      base_q      <= '0;
      end_q       <= '0;
      w_addr_q    <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_sum_q   <= '0;
      // NOTE: the wide spike register is reset too, so no stale vector survives an aborted pass.
      spk_q       <= '0;
    end else begin
      row_q       <= row_d;
      ptr_addr_q  <= ptr_addr_d;
      base_q      <= base_d;
      end_q       <= end_d;
      w_addr_q    <= w_addr_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_sum_q   <= out_sum_d;
      spk_q       <= spk_d;
    end
  end

  assign mem.ptr_addr = ptr_addr_q;
  assign mem.w_addr   = w_addr_q;
  assign out_valid    = out_valid_q;
  assign out_row      = out_row_q;
  assign out_sum      = out_sum_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_csr_spike_accum.sv
// Bench for csr_spike_accum: synchronous memory models, a row-sum model computed
// straight from the CSR table, a per-cycle output monitor and directed passes.
module tb_csr_spike_accum;

  localparam int N_ROWS = 10;
  localparam int N_IN   = 1000;
  localparam int ACC_W  = 8;
  localparam int ROW_W  = 4;
  localparam int BUDGET = 1000;
  localparam int SAT_HI = 127;
  localparam int SAT_LO = -128;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [N_IN-1:0]         spikes;
  logic                    out_valid;
  logic [ROW_W-1:0]        out_row;
  logic signed [ACC_W-1:0] out_sum;
  logic                    busy;
  logic                    done;

  csr_spike_accum_if #(.ROW_W(ROW_W)) mem_if ();

  csr_spike_accum #(.N_ROWS(N_ROWS), .N_IN(N_IN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .spikes    (spikes),
    .mem       (mem_if),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_sum   (out_sum),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory contents
  logic        [13:0] ptr_rom [16];
  logic signed [7:0]  wt_mem  [16384];
  logic        [9:0]  idx_mem [16384];

  // Synchronous memories: data valid one cycle after the address.
  always @(posedge clk) begin
    mem_if.ptr_data <= ptr_rom[mem_if.ptr_addr];
    mem_if.w_weight <= wt_mem[mem_if.w_addr];
    mem_if.w_index  <= idx_mem[mem_if.w_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sum [N_ROWS];
  int got_sum [N_ROWS];
  int next_row;
  int done_cnt;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Row sum from the CSR definition: words [end(r-1), end(r)), gated by spikes,
  // clamped to the ACC_W range and frozen once clamped.
  function automatic int model_row(input int r, input logic [N_IN-1:0] spk);
    int  lo, hi, acc, ix;
    bit  sat;
    lo  = (r == 0) ? 0 : int'(ptr_rom[r-1]);
    hi  = int'(ptr_rom[r]);
    acc = 0;
    sat = 1'b0;
    for (int a = lo; a < hi; a++) begin
      ix = int'(idx_mem[a]);
      if (!sat && ix < N_IN && spk[ix]) begin
        acc += int'(wt_mem[a]);
        if (acc > SAT_HI) begin acc = SAT_HI; sat = 1'b1; end
        else if (acc < SAT_LO) begin acc = SAT_LO; sat = 1'b1; end
      end
    end
    return acc;
  endfunction

  // Output monitor: every out_valid must be the next row in order with the model's sum.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (next_row >= N_ROWS) begin
          check("extra_valid", next_row, N_ROWS - 1);
        end else begin
          check("out_row", out_row, next_row);
          check("out_sum", out_sum, exp_sum[next_row]);
          got_sum[next_row] = int'(out_sum);
          next_row++;
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic init_tables();
    int ends [N_ROWS] = '{2, 2, 5, 45, 85, 88, 80, 90, 92, 92};
    for (int a = 0; a < 16384; a++) begin
      wt_mem[a]  = '0;
      idx_mem[a] = '0;
    end
    for (int r = 0; r < 16; r++) ptr_rom[r] = '0;
    for (int r = 0; r < N_ROWS; r++) ptr_rom[r] = 14'(ends[r]);
    // Row 0 {+3,-1}, row 1 empty, row 2 {+7,+2,-4}
    wt_mem[0] = 8'sd3;  idx_mem[0] = 10'd10;
    wt_mem[1] = -8'sd1; idx_mem[1] = 10'd20;
    wt_mem[2] = 8'sd7;  idx_mem[2] = 10'd30;
    wt_mem[3] = 8'sd2;  idx_mem[3] = 10'd40;
    wt_mem[4] = -8'sd4; idx_mem[4] = 10'd50;
    // Row 3: 40 x +127, row 4: 40 x -128
    for (int k = 0; k < 40; k++) begin
      wt_mem[5 + k]  = 8'sd127;   idx_mem[5 + k]  = 10'(100 + k);
      wt_mem[45 + k] = -8'sd128;  idx_mem[45 + k] = 10'(140 + k);
    end
    // Row 5: index 1023 and 1000 are outside the spike vector, 999 is inside
    wt_mem[85] = 8'sd5; idx_mem[85] = 10'd1023;
    wt_mem[86] = 8'sd1; idx_mem[86] = 10'd999;
    wt_mem[87] = 8'sd9; idx_mem[87] = 10'd1000;
    // Row 6 is malformed (end 80 < base 88); row 7 re-reads 80..89
    wt_mem[88] = 8'sd100; idx_mem[88] = 10'd5;
    wt_mem[89] = 8'sd50;  idx_mem[89] = 10'd6;
    // Row 8 {-3,+4}, row 9 empty
    wt_mem[90] = -8'sd3; idx_mem[90] = 10'd7;
    wt_mem[91] = 8'sd4;  idx_mem[91] = 10'd8;
  endtask

  task automatic start_pass(input logic [N_IN-1:0] spk);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 20) begin @(negedge clk); c++; end
    check("idle_before_start", busy, 0);
    for (int r = 0; r < N_ROWS; r++) begin
      exp_sum[r] = model_row(r, spk);
      got_sum[r] = 9999;
    end
    next_row = 0;
    done_cnt = 0;
    @(negedge clk);
    start  = 1'b1;
    spikes = spk;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // One full pass; with perturb set, start is re-pulsed with a zero vector
  // during the pass and again on the done cycle.
  task automatic run_pass(input logic [N_IN-1:0] spk, input bit perturb);
    bit got_done, dropped;
    start_pass(spk);
    got_done = 1'b0;
    dropped  = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        got_done = 1'b1;
        check("busy_at_done", busy, 1);
        if (perturb) start = 1'b1;
        break;
      end
      if (busy !== 1'b1) dropped = 1'b1;
      if (perturb && (c % 7 == 3)) begin
        start  = 1'b1;
        spikes = '0;
      end
    end
    check("done_seen", got_done, 1);
    check("busy_held", dropped, 0);
    check("rows_emitted", next_row, N_ROWS);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_released", busy, 0);
    check("done_count", done_cnt, 1);
  endtask

  logic [N_IN-1:0] all_on;
  logic [N_IN-1:0] spk_v;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    spikes = '0;
    next_row = 0;
    done_cnt = 0;
    for (int r = 0; r < N_ROWS; r++) begin exp_sum[r] = 0; got_sum[r] = 0; end
    init_tables();
    all_on = '1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_row", out_row, 0);
    check("rst_w_addr", mem_if.w_addr, 0);
    check("rst_ptr_addr", mem_if.ptr_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All inputs spiking
    run_pass(all_on, 1'b0);
    check("p1_row0", got_sum[0], 2);
    check("p1_row1_empty", got_sum[1], 0);
    check("p1_row2", got_sum[2], 5);
    check("p1_row3_sat_hi", got_sum[3], 127);
    check("p1_row4_sat_lo", got_sum[4], -128);
    check("p1_row5_idx_range", got_sum[5], 1);
    check("p1_row6_malformed", got_sum[6], 0);
    check("p1_row7_sticky", got_sum[7], -128);
    check("p1_row8", got_sum[8], 1);
    check("p1_row9_empty", got_sum[9], 0);

    // Only the +7 weight's column spiking
    spk_v = '0;
    spk_v[30] = 1'b1;
    run_pass(spk_v, 1'b0);
    check("p2_row0", got_sum[0], 0);
    check("p2_row2", got_sum[2], 7);
    check("p2_row3", got_sum[3], 0);

    // Mixed columns
    spk_v = '0;
    spk_v[10] = 1'b1;
    spk_v[40] = 1'b1;
    spk_v[7]  = 1'b1;
    run_pass(spk_v, 1'b0);
    check("p3_row0", got_sum[0], 3);
    check("p3_row2", got_sum[2], 2);
    check("p3_row8", got_sum[8], -3);

    // Start re-pulsed during the pass with a different vector
    run_pass(all_on, 1'b1);
    check("p4_row2", got_sum[2], 5);
    check("p4_row3", got_sum[3], 127);
    check("p4_row7", got_sum[7], -128);

    // Reset in the middle of row 3's stream
    start_pass(all_on);
    for (int c = 0; c < BUDGET && next_row < 3; c++) @(negedge clk);
    check("reach_row3", next_row, 3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_w_addr", mem_if.w_addr, 0);
    check("midrst_ptr_addr", mem_if.ptr_addr, 0);
    check("midrst_out_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_rst_idle", busy, 0);
    check("after_rst_no_done", done_cnt, 0);

    // Fresh pass after the aborted one starts again at row 0
    run_pass(all_on, 1'b0);
    check("p5_row0", got_sum[0], 2);
    check("p5_row3", got_sum[3], 127);
    check("p5_row9", got_sum[9], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
